bcd2bin: RTL and testbench
==========================

BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start_i, input, 1 bit: conversion request, sampled on clock edges.
REQ-004 SHALL have ports uni_i, dec_i, cen_i, mil_i and mil10_i, each input, 4 bits: BCD digits for units, tens, hundreds, thousands and ten-thousands.
REQ-005 SHALL have port bin_o, output, 16 bits: binary result, registered.
REQ-006 SHALL have port busy_o, output, 1 bit: high while a conversion is in progress.
REQ-007 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-008 SHALL have port err_o, output, 1 bit: status of the last completed conversion (invalid digit or overflow).

Function
REQ-009 SHALL implement FSM states IDLE, SHIFT and DONE; reset state is IDLE.
REQ-010 In IDLE or DONE, start_i=1 at a rising edge SHALL capture all five digits into a 20-bit BCD register, clear a 16-bit shift register and a 4-bit iteration counter, set busy_o=1, and go to SHIFT.
REQ-011 If any captured digit is greater than 9, the FSM SHALL skip SHIFT and go straight to DONE on that edge with an invalid flag set.
REQ-012 Each SHIFT cycle SHALL perform one reverse double-dabble step:
- shift the 36-bit concatenation {BCD register, shift register} right by 1;
- then, for each BCD nibble whose value is 8 or more, subtract 3 from it.
REQ-013 SHIFT SHALL last exactly 16 cycles, with the counter counting 0..15; on the edge where the counter equals 15, the FSM SHALL go to DONE.
REQ-014 On entry to DONE, outputs SHALL be set as follows:
- valid digits, BCD register zero: bin_o = shift register, err_o=0;
- valid digits, BCD register nonzero (value above 65535): bin_o=16'hFFFF (saturated), err_o=1;
- invalid digit: bin_o=16'h0000, err_o=1.
REQ-015 done_o SHALL be 1 for exactly the one cycle spent in DONE; busy_o SHALL be 0 in DONE and in IDLE.
REQ-016 Latency SHALL be as follows:
- valid input: done_o high in cycle N+17 when start is sampled at edge N;
- invalid input: done_o high in cycle N+1.
REQ-017 start_i SHALL be ignored while in SHIFT; digit inputs SHALL be ignored except at the capture edge.
REQ-018 From DONE, the FSM SHALL return to IDLE unless start_i=1, in which case a new capture SHALL occur (back-to-back operation with no idle cycle).
REQ-019 bin_o and err_o SHALL hold their values until the next entry to DONE.

Reset
REQ-020 rst_ni=0 SHALL immediately force, regardless of clock:
- state IDLE;
- bin_o=0, busy_o=0, done_o=0, err_o=0;
- BCD register, shift register and counter all 0.
REQ-021 Reset asserted during SHIFT SHALL abort the conversion with no done_o pulse, and the first start after reset release SHALL behave exactly as from power-up.

Verification
REQ-022 Digits 1,2,3,4,5 (mil10..uni) with start pulse -> done_o pulse 17 cycles later, bin_o=16'h3039, err_o=0, busy_o high for 16 cycles.
REQ-023 Digits 6,5,5,3,5 -> bin_o=16'hFFFF, err_o=0; then digits 6,5,5,3,6 -> bin_o=16'hFFFF, err_o=1; then 9,9,9,9,9 -> bin_o=16'hFFFF, err_o=1.
REQ-024 Digits 0,0,0,0,0 -> bin_o=0, err_o=0 after 17 cycles; digits 0,0,0,10,0 -> done_o the next cycle, bin_o=0, err_o=1, busy_o never high.
REQ-025 start_i held high continuously with digits 0,0,0,4,2 -> done_o pulses every 17 cycles, bin_o=16'h002A each time; a start pulse injected mid-SHIFT does not change the timing.
REQ-026 rst_ni driven low asynchronously 8 cycles into a conversion -> outputs 0 immediately, no done_o; after release, a start with 0,0,0,0,7 -> bin_o=16'h0007 after 17 cycles.

Source files
------------

// File: rtl/bcd2bin.sv
// Sequential five-digit BCD to 16-bit binary converter.
// A reverse double-dabble datapath retires one binary bit per cycle, so a valid
// conversion takes 16 SHIFT cycles. Invalid digits skip straight to DONE.
// Results above 65535 saturate to 16'hFFFF and raise err_o.
module bcd2bin (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [3:0]  uni_i,
  input  logic [3:0]  dec_i,
  input  logic [3:0]  cen_i,
  input  logic [3:0]  mil_i,
  input  logic [3:0]  mil10_i,
  output logic [15:0] bin_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [19:0] bcd_q, bcd_d;
  logic [15:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bin_q, bin_d;
  logic        err_q, err_d;

  logic [19:0] digits;
  logic        digits_invalid;
  logic [19:0] bcd_step;
  logic [15:0] sr_step;

  assign digits = {mil10_i, mil_i, cen_i, dec_i, uni_i};

  // A digit is invalid when its nibble exceeds 9.
  always_comb begin
    digits_invalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (digits[4*i +: 4] > 4'd9) digits_invalid = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then correct nibbles >= 8.
  always_comb begin
    logic [35:0] shifted;
    logic [3:0]  nib;
    shifted  = {bcd_q, sr_q} >> 1;
    sr_step  = shifted[15:0];
    bcd_step = shifted[35:16];
    for (int i = 0; i < 5; i++) begin
      nib = bcd_step[4*i +: 4];
      if (nib >= 4'd8) nib = nib - 4'd3;
      bcd_step[4*i +: 4] = nib;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          bcd_d = digits;
          sr_d  = 16'h0000;
          cnt_d = 4'd0;
          if (digits_invalid) begin
            state_d = StDone;
            bin_d   = 16'h0000;
            err_d   = 1'b1;
          end else begin
            state_d = StShift;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        bcd_d = bcd_step;
        sr_d  = sr_step;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = StDone;
          // Any residue left in the BCD register means the value exceeded 16 bits.
          if (bcd_step == 20'h00000) begin
            bin_d = sr_step;
            err_d = 1'b0;
          end else begin
            bin_d = 16'hFFFF;
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      bcd_q   <= 20'h00000;
      sr_q    <= 16'h0000;
      cnt_q   <= 4'd0;
      bin_q   <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bin_o  = bin_q;
  assign err_o  = err_q;
  assign busy_o = (state_q == StShift);
  assign done_o = (state_q == StDone);

endmodule

// File: tb/tb_bcd2bin.sv
// Directed self-checking bench for bcd2bin.
module tb_bcd2bin;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [3:0]  uni_i, dec_i, cen_i, mil_i, mil10_i;
  logic [15:0] bin_o;
  logic        busy_o, done_o, err_o;

  int checks = 0;
  int errors = 0;

  bcd2bin dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .uni_i   (uni_i),
    .dec_i   (dec_i),
    .cen_i   (cen_i),
    .mil_i   (mil_i),
    .mil10_i (mil10_i),
    .bin_o   (bin_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Present digits with a one-cycle start pulse; returns just after the capture edge.
  task automatic start_conv(input logic [3:0] m10, input logic [3:0] m, input logic [3:0] c,
                            input logic [3:0] d, input logic [3:0] u);
    @(negedge clk_i);
    mil10_i = m10; mil_i = m; cen_i = c; dec_i = d; uni_i = u;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Count falling edges until done_o is seen; lat = -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        lat = i;
        break;
      end
      if (busy_o) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0;
    uni_i = 4'd0; dec_i = 4'd0; cen_i = 4'd0; mil_i = 4'd0; mil10_i = 4'd0;
    #3;
    checks++;
    if ({bin_o, busy_o, done_o, err_o} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got bin=%h busy=%b done=%b err=%b want all 0",
               bin_o, busy_o, done_o, err_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({busy_o, done_o} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    start_conv(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    wait_done(lat, bc);
    checks++;
    if (lat !== 16) begin
      errors++; $display("FAIL basic_latency got %0d want 16", lat);
    end
    checks++;
    if (bc !== 16) begin
      errors++; $display("FAIL basic_busy_cycles got %0d want 16", bc);
    end
    checks++;
    if ({bin_o, err_o, busy_o} !== {16'h3039, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result got bin=%h err=%b busy=%b want 3039 0 0", bin_o, err_o, busy_o);
    end
    // Result must hold after returning to IDLE; done is a single pulse.
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b0) begin
      errors++; $display("FAIL done_one_cycle got %b want 0", done_o);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if ({bin_o, err_o} !== {16'h3039, 1'b0}) begin
      errors++; $display("FAIL hold_result got bin=%h err=%b want 3039 0", bin_o, err_o);
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    start_conv(4'd6, 4'd5, 4'd5, 4'd3, 4'd5);
    wait_done(lat, bc);
    checks++;
    if ({lat == 16, bin_o, err_o} !== {1'b1, 16'hFFFF, 1'b0}) begin
      errors++;
      $display("FAIL max_65535 got lat=%0d bin=%h err=%b want 16 ffff 0", lat, bin_o, err_o);
    end
    start_conv(4'd6, 4'd5, 4'd5, 4'd3, 4'd6);
    wait_done(lat, bc);
    checks++;
    if ({lat == 16, bin_o, err_o} !== {1'b1, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL ovf_65536 got lat=%0d bin=%h err=%b want 16 ffff 1", lat, bin_o, err_o);
    end
    start_conv(4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    wait_done(lat, bc);
    checks++;
    if ({lat == 16, bin_o, err_o} !== {1'b1, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL ovf_99999 got lat=%0d bin=%h err=%b want 16 ffff 1", lat, bin_o, err_o);
    end
  endtask

  task automatic test_zero_invalid();
    int lat, bc;
    start_conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    wait_done(lat, bc);
    checks++;
    if ({lat == 16, bin_o, err_o} !== {1'b1, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL zero got lat=%0d bin=%h err=%b want 16 0000 0", lat, bin_o, err_o);
    end
    // Leave a nonzero result first so the invalid path's clear is observable.
    start_conv(4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
    wait_done(lat, bc);
    start_conv(4'd0, 4'd0, 4'd0, 4'd10, 4'd0);
    wait_done(lat, bc);
    checks++;
    if (lat !== 0) begin
      errors++; $display("FAIL invalid_latency got %0d want 0", lat);
    end
    checks++;
    if (bc !== 0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL invalid_busy got cycles=%0d busy=%b want 0 0", bc, busy_o);
    end
    checks++;
    if ({bin_o, err_o} !== {16'h0000, 1'b1}) begin
      errors++; $display("FAIL invalid_result got bin=%h err=%b want 0000 1", bin_o, err_o);
    end
    start_conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd15);
    wait_done(lat, bc);
    checks++;
    if ({lat == 0, bin_o, err_o} !== {1'b1, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL invalid_units got lat=%0d bin=%h err=%b want 0 0000 1", lat, bin_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    @(negedge clk_i);
    mil10_i = 4'd0; mil_i = 4'd0; cen_i = 4'd0; dec_i = 4'd4; uni_i = 4'd2;
    start_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(lat, bc);
      checks++;
      if ({lat == 16, bc == 16, bin_o, err_o} !== {1'b1, 1'b1, 16'h002A, 1'b0}) begin
        errors++;
        $display("FAIL b2b_pulse%0d got lat=%0d busy=%0d bin=%h err=%b want 16 16 002a 0",
                 k, lat, bc, bin_o, err_o);
      end
    end
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_mid_shift_start();
    int lat;
    lat = -1;
    start_conv(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        lat = i;
        break;
      end
      if (i == 5) begin
        start_i = 1'b1;
        mil10_i = 4'd15; mil_i = 4'd15; cen_i = 4'd15; dec_i = 4'd15; uni_i = 4'd15;
      end
      if (i == 6) start_i = 1'b0;
    end
    checks++;
    if ({lat == 16, bin_o, err_o} !== {1'b1, 16'h3039, 1'b0}) begin
      errors++;
      $display("FAIL mid_shift_start got lat=%0d bin=%h err=%b want 16 3039 0", lat, bin_o, err_o);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, done_seen;
    start_conv(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    repeat (8) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({bin_o, busy_o, done_o, err_o} !== 19'd0) begin
      errors++;
      $display("FAIL abort_outputs got bin=%h busy=%b done=%b err=%b want all 0",
               bin_o, busy_o, done_o, err_o);
    end
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (done_o) done_seen++;
      if (i == 4) rst_ni = 1'b1;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen);
    end
    start_conv(4'd0, 4'd0, 4'd0, 4'd0, 4'd7);
    wait_done(lat, bc);
    checks++;
    if ({lat == 16, bc == 16, bin_o, err_o} !== {1'b1, 1'b1, 16'h0007, 1'b0}) begin
      errors++;
      $display("FAIL after_abort got lat=%0d busy=%0d bin=%h err=%b want 16 16 0007 0",
               lat, bc, bin_o, err_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero_invalid();
    test_back_to_back();
    test_mid_shift_start();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
